pg_sequencer: RTL and testbench
===============================

Name: pg_sequencer

Overview:
- Segment scheduler that drives one profile_gen instance.
- Buffers motion segment descriptors (velocity, accel, jerk, step count) in a small FIFO.
- For each segment it loads the descriptor into profile_gen parameter registers over the param write port, then issues a programmed number of acc_step pulses at a fixed divided rate.
- Sits between the host register/command interface and profile_gen; one sequencer per axis.

Parameters:
- DEPTH, 4, segment FIFO depth in entries (power of 2, ≥2).
- DIV_W, 16, width of step rate divider.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_valid  in  1  host presents a segment descriptor.
- seg_ready  out  1  FIFO not full; push occurs when seg_valid && seg_ready.
- seg_v  in  32  signed velocity, written to profile_gen addr 3.
- seg_a  in  32  signed acceleration, written to addr 4.
- seg_j  in  32  signed jerk, written to addr 5.
- seg_steps  in  32  unsigned acc_step count for the segment.
- step_div  in  DIV_W  clocks per acc_step; 0 treated as 1; sampled on every RUN cycle.
- start  in  1  one-cycle pulse, begin executing the FIFO.
- abort  in  1  one-cycle pulse, stop immediately.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- seg_count  out  8  segments fully completed since start (wraps at 255→0).
- pg_param_addr  out  8  to profile_gen param_addr.
- pg_param_in  out  32  to profile_gen param_in.
- pg_write_hi  out  1  to profile_gen param_write_hi.
- pg_write_lo  out  1  to profile_gen param_write_lo.
- pg_acc_step  out  1  to profile_gen acc_step.

Behaviour:
- Reset values:
  - All pg_* outputs 0; busy 0; done 0; seg_count 0.
  - FIFO empty, so seg_ready 1.
  - State IDLE.
- All outputs are registered.
- FIFO:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Push when full is ignored (seg_ready is 0).
  - Pop occurs only on entry to LOAD.
- FSM states: IDLE, CLEAR, LOAD, RUN, HALT.
- IDLE:
  - start with FIFO empty: go HALT.
  - start with FIFO non-empty: go CLEAR if the feature is enabled, else LOAD.
  - On start, seg_count is set to 0.
- LOAD, 6 cycles: pops the head entry, then writes one word per cycle:
  - addr3 lo = seg_v, then addr3 hi = {32{seg_v[31]}}
  - addr4 lo = seg_a, then addr4 hi = sign-extension of seg_a
  - addr5 lo = seg_j, then addr5 hi = sign-extension of seg_j
  - Exactly one of pg_write_lo / pg_write_hi is high in each LOAD cycle.
- RUN:
  - A divider counter starts at 0 on entry.
  - pg_acc_step pulses for one cycle every max(step_div,1) cycles; the first pulse comes max(step_div,1) cycles after RUN entry.
  - Each pulse decrements the remaining-step counter.
  - The cycle after the pulse that reaches 0: seg_count increments, then go LOAD if the FIFO is non-empty, else HALT.
  - seg_steps = 0: RUN is bypassed. LOAD goes directly to the next LOAD or HALT, and seg_count still increments.
- HALT, 2 cycles:
  - Writes addr4 and addr5 with write_hi = write_lo = 1 and param_in = 0, so velocity holds and accel/jerk stop.
  - Then go IDLE and pulse done.
- abort in CLEAR, LOAD or RUN:
  - Flush the FIFO.
  - Any LOAD write in flight completes in that cycle.
  - No further acc_step; go HALT next cycle.
  - seg_count is not incremented for the aborted segment.
- abort in IDLE or HALT: flush the FIFO only.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- Reset mid-operation: all state returns to reset values immediately; profile_gen contents are not touched.

Optional Feature:
- Macro PG_SEQ_CLEAR_EN.
- Defined:
  - The CLEAR state is executed on start: 3 cycles writing addr 0, 1, 2 with write_hi = write_lo = 1 and param_in = 0, zeroing position, velocity and accel state.
  - Then go LOAD.
- Undefined: the CLEAR state is absent and start goes directly to LOAD.

Test Plan:
- Reset: hold rst_n=0 for 2 clks → all pg_* = 0, seg_ready = 1, busy = 0.
- Single segment: push v=3, a=4, j=5, steps=3, step_div=100; pulse start.
  - LOAD issues addr/data sequence (3,3,lo)(3,0,hi)(4,4,lo)(4,0,hi)(5,5,lo)(5,0,hi).
  - Exactly 3 acc_step pulses, spaced 100 clks apart.
  - HALT writes addr4/5 = 0; done pulses; seg_count = 1.
- Back-to-back and sign: push 2 segments, second with a = −1.
  - Second LOAD follows the first RUN with no IDLE gap.
  - addr4 hi written as 0xFFFFFFFF.
  - seg_count = 2.
- FIFO full: push DEPTH=4 entries without start → seg_ready = 0; a 5th push is ignored; start executes exactly 4 segments.
- Abort and zero steps:
  - abort during RUN after 1 of 10 steps → no further acc_step, HALT writes, done, seg_count = 0, FIFO empty.
  - A steps=0 segment produces a LOAD with no acc_step.
- PG_SEQ_CLEAR_EN compiled in: start → addr 0, 1, 2 written with hi = lo = 1, data 0, before the first LOAD; without the macro, the first write is addr 3.

Source files
------------

// File: rtl/pg_sequencer.sv
// Segment scheduler: buffers motion descriptors, loads them into profile_gen and paces acc_step.
// Optional CLEAR phase (zero position/velocity/accel on start) enabled by `define PG_SEQ_CLEAR_EN.
module pg_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seg_valid,
    output logic             seg_ready,
    input  logic [31:0]      seg_v,
    input  logic [31:0]      seg_a,
    input  logic [31:0]      seg_j,
    input  logic [31:0]      seg_steps,
    input  logic [DIV_W-1:0] step_div,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [7:0]       seg_count,
    output logic [7:0]       pg_param_addr,
    output logic [31:0]      pg_param_in,
    output logic             pg_write_hi,
    output logic             pg_write_lo,
    output logic             pg_acc_step
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {StIdle, StClear, StLoad, StRun, StHalt} state_e;

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_phase, w_phase_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [31:0]       r_rem, w_rem_nxt;
    logic [127:0]      r_cur, w_cur_nxt;   // {v, a, j, steps} of the segment being executed
    logic [127:0]      r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [AW:0]       r_count, w_count_nxt;

    logic              w_push, w_pop, w_flush, w_step, w_done, w_empty;
    logic [7:0]        w_seg_count_nxt;
    logic [DIV_W-1:0]  w_div_max;
    logic              w_div_hit;
    logic [7:0]        w_addr;
    logic [31:0]       w_data, w_word;
    logic              w_hi, w_lo;

    assign w_push    = seg_valid && seg_ready && !w_flush;
    assign w_empty   = (r_count == '0);
    assign w_div_max = (step_div == '0) ? DIV_W'(1) : step_div;
    assign w_div_hit = (r_div >= w_div_max - DIV_W'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_div_nxt       = r_div;
        w_rem_nxt       = r_rem;
        w_pop           = 1'b0;
        w_flush         = 1'b0;
        w_step          = 1'b0;
        w_done          = 1'b0;
        w_seg_count_nxt = seg_count;
        case (r_state)
            StIdle: begin
                if (abort) begin
                    w_flush = 1'b1;
                end else if (start) begin
                    w_seg_count_nxt = 8'd0;
                    w_phase_nxt     = 3'd0;
                    if (w_empty) begin
                        w_state_nxt = StHalt;
                    end else begin
`ifdef PG_SEQ_CLEAR_EN
                        w_state_nxt = StClear;
`else
                        w_state_nxt = StLoad;
                        w_pop       = 1'b1;
`endif
                    end
                end
            end
`ifdef PG_SEQ_CLEAR_EN
            StClear: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = StHalt;
                    w_phase_nxt = 3'd0;
                end else if (r_phase == 3'd2) begin
                    w_state_nxt = StLoad;
                    w_phase_nxt = 3'd0;
                    w_pop       = 1'b1;
                end else begin
                    w_phase_nxt = r_phase + 3'd1;
                end
            end
`endif
            StLoad: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = StHalt;
                    w_phase_nxt = 3'd0;
                end else if (r_phase == 3'd5) begin
                    w_phase_nxt = 3'd0;
                    if (r_cur[31:0] == 32'd0) begin
                        // zero-step segment completes without entering RUN
                        w_seg_count_nxt = seg_count + 8'd1;
                        w_state_nxt     = w_empty ? StHalt : StLoad;
                        w_pop           = !w_empty;
                    end else begin
                        w_state_nxt = StRun;
                        w_div_nxt   = '0;
                        w_rem_nxt   = r_cur[31:0];
                    end
                end else begin
                    w_phase_nxt = r_phase + 3'd1;
                end
            end
            StRun: begin
                w_phase_nxt = 3'd0;
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = StHalt;
                end else if (r_rem == 32'd0) begin
                    w_seg_count_nxt = seg_count + 8'd1;
                    w_state_nxt     = w_empty ? StHalt : StLoad;
                    w_pop           = !w_empty;
                end else if (w_div_hit) begin
                    w_step    = 1'b1;
                    w_div_nxt = '0;
                    w_rem_nxt = r_rem - 32'd1;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            StHalt: begin
                w_flush = abort;
                if (r_phase == 3'd1) begin
                    w_state_nxt = StIdle;
                    w_phase_nxt = 3'd0;
                    w_done      = 1'b1;
                end else begin
                    w_phase_nxt = r_phase + 3'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_phase_nxt = 3'd0;
            end
        endcase
    end

    assign w_cur_nxt = w_pop ? r_mem[r_rd_ptr] : r_cur;

    always_comb begin
        if (w_flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Parameter-port outputs are decoded from the next state so writes line up with state cycles.
    always_comb begin
        w_addr = 8'd0;
        w_data = 32'd0;
        w_hi   = 1'b0;
        w_lo   = 1'b0;
        w_word = 32'd0;
        case (w_state_nxt)
            StClear: begin
                w_addr = {5'd0, w_phase_nxt};
                w_hi   = 1'b1;
                w_lo   = 1'b1;
            end
            StLoad: begin
                case (w_phase_nxt[2:1])
                    2'd0:    w_word = w_cur_nxt[127:96];
                    2'd1:    w_word = w_cur_nxt[95:64];
                    default: w_word = w_cur_nxt[63:32];
                endcase
                w_addr = 8'd3 + {6'd0, w_phase_nxt[2:1]};
                w_hi   = w_phase_nxt[0];
                w_lo   = !w_phase_nxt[0];
                w_data = w_phase_nxt[0] ? {32{w_word[31]}} : w_word;
            end
            StHalt: begin
                w_addr = 8'd4 + {7'd0, w_phase_nxt[0]};
                w_hi   = 1'b1;
                w_lo   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {seg_v, seg_a, seg_j, seg_steps};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_phase       <= 3'd0;
            r_div         <= '0;
            r_rem         <= 32'd0;
            r_cur         <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            seg_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            seg_count     <= 8'd0;
            pg_param_addr <= 8'd0;
            pg_param_in   <= 32'd0;
            pg_write_hi   <= 1'b0;
            pg_write_lo   <= 1'b0;
            pg_acc_step   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_div         <= w_div_nxt;
            r_rem         <= w_rem_nxt;
            r_cur         <= w_cur_nxt;
            r_count       <= w_count_nxt;
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            seg_ready     <= (w_count_nxt != (AW+1)'(DEPTH));
            busy          <= (w_state_nxt != StIdle);
            done          <= w_done;
            seg_count     <= w_seg_count_nxt;
            pg_param_addr <= w_addr;
            pg_param_in   <= w_data;
            pg_write_hi   <= w_hi;
            pg_write_lo   <= w_lo;
            pg_acc_step   <= w_step;
        end
    end
endmodule

// File: tb/tb_pg_sequencer.sv
// Directed bench for pg_sequencer: table of single-segment scenarios plus multi-cycle sequences.
module tb_pg_sequencer;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
`ifdef PG_SEQ_CLEAR_EN
    localparam int NCLR = 3;
`else
    localparam int NCLR = 0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic seg_valid = 1'b0, start = 1'b0, abort = 1'b0;
    logic [31:0] seg_v = '0, seg_a = '0, seg_j = '0, seg_steps = '0;
    logic [DIV_W-1:0] step_div = '0;
    logic seg_ready, busy, done, pg_write_hi, pg_write_lo, pg_acc_step;
    logic [7:0] seg_count, pg_param_addr;
    logic [31:0] pg_param_in;

    pg_sequencer #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .seg_v(seg_v), .seg_a(seg_a), .seg_j(seg_j), .seg_steps(seg_steps),
        .step_div(step_div), .start(start), .abort(abort), .busy(busy), .done(done),
        .seg_count(seg_count), .pg_param_addr(pg_param_addr), .pg_param_in(pg_param_in),
        .pg_write_hi(pg_write_hi), .pg_write_lo(pg_write_lo), .pg_acc_step(pg_acc_step)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        hi;
        logic        lo;
    } wr_t;

    typedef struct {
        logic [31:0] v, a, j, steps;
        logic [15:0] div;
        logic [31:0] v_hi, a_hi, j_hi;
    } vec_t;

    wr_t wq[$];
    int  wt[$];
    int  st[$];
    int  dcnt = 0;
    int  cyc = 0;
    int  n_checks = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pg_write_hi || pg_write_lo) begin
            wq.push_back('{addr: pg_param_addr, data: pg_param_in, hi: pg_write_hi,
                           lo: pg_write_lo});
            wt.push_back(cyc);
        end
        if (pg_acc_step) st.push_back(cyc);
        if (done) dcnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        wt.delete();
        st.delete();
        dcnt = 0;
    endtask

    // Callers sit 1 time unit after a rising edge.
    task automatic push(input logic [31:0] v, a, j, s);
        seg_valid = 1'b1;
        seg_v = v; seg_a = a; seg_j = j; seg_steps = s;
        @(posedge clk); #1;
        seg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_timeout"}, 64'(n >= 5000), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic wr_t exp_wr(input int k, input vec_t t);
        wr_t w;
        int  m;
        logic [31:0] lo_w, hi_w;
        if (k < NCLR) return '{addr: 8'(k), data: 32'd0, hi: 1'b1, lo: 1'b1};
        m = k - NCLR;
        if (m >= 6) return '{addr: 8'(4 + m - 6), data: 32'd0, hi: 1'b1, lo: 1'b1};
        case (m / 2)
            0: begin lo_w = t.v; hi_w = t.v_hi; end
            1: begin lo_w = t.a; hi_w = t.a_hi; end
            default: begin lo_w = t.j; hi_w = t.j_hi; end
        endcase
        w.addr = 8'(3 + m / 2);
        w.hi   = (m % 2) == 1;
        w.lo   = (m % 2) == 0;
        w.data = w.hi ? hi_w : lo_w;
        return w;
    endfunction

    vec_t tbl[4];
    int   eff;
    int   nld;

    initial begin
        tbl[0] = '{v: 32'd3, a: 32'd4, j: 32'd5, steps: 32'd3, div: 16'd100,
                   v_hi: 32'h0, a_hi: 32'h0, j_hi: 32'h0};
        tbl[1] = '{v: 32'hFFFF_FFFE, a: 32'h7FFF_FFFF, j: 32'h8000_0000, steps: 32'd1,
                   div: 16'd1, v_hi: 32'hFFFF_FFFF, a_hi: 32'h0, j_hi: 32'hFFFF_FFFF};
        tbl[2] = '{v: 32'd0, a: 32'hFFFF_FFFF, j: 32'd1, steps: 32'd0, div: 16'd7,
                   v_hi: 32'h0, a_hi: 32'hFFFF_FFFF, j_hi: 32'h0};
        tbl[3] = '{v: 32'h1234_5678, a: 32'h8000_0001, j: 32'hFFFF_FF9C, steps: 32'd2,
                   div: 16'd0, v_hi: 32'h0, a_hi: 32'hFFFF_FFFF, j_hi: 32'hFFFF_FFFF};

        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", 64'(pg_param_addr), 64'd0);
        check("rst_pgctl", 64'({pg_param_in, pg_write_hi, pg_write_lo, pg_acc_step}), 64'd0);
        check("rst_ready", 64'(seg_ready), 64'd1);
        check("rst_busy_done_cnt", 64'({busy, done, seg_count}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            clear_mon();
            step_div = tbl[i].div;
            eff = (tbl[i].div == 0) ? 1 : int'(tbl[i].div);
            push(tbl[i].v, tbl[i].a, tbl[i].j, tbl[i].steps);
            pulse_start();
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            wait_done($sformatf("v%0d", i));
            check($sformatf("v%0d_nwr", i), 64'(wq.size()), 64'(NCLR + 8));
            for (int k = 0; k < wq.size() && k < NCLR + 8; k++)
                check($sformatf("v%0d_wr%0d", i, k), 64'(wq[k]), 64'(exp_wr(k, tbl[i])));
            check($sformatf("v%0d_nstep", i), 64'(st.size()), 64'(tbl[i].steps));
            if (st.size() > 0 && wt.size() == NCLR + 8) begin
                check($sformatf("v%0d_first_gap", i), 64'(st[0] - wt[NCLR + 5]), 64'(eff + 1));
                for (int k = 1; k < st.size(); k++)
                    check($sformatf("v%0d_space%0d", i, k), 64'(st[k] - st[k-1]), 64'(eff));
                check($sformatf("v%0d_halt_gap", i), 64'(wt[NCLR + 6] - st[st.size()-1]), 64'd1);
            end else if (wt.size() == NCLR + 8) begin
                check($sformatf("v%0d_halt_gap0", i), 64'(wt[NCLR + 6] - wt[NCLR + 5]), 64'd1);
            end
            check($sformatf("v%0d_segcnt", i), 64'(seg_count), 64'd1);
            check($sformatf("v%0d_idle", i), 64'({busy, dcnt[7:0]}), 64'h001);
        end

        // Back-to-back with negative accel: second LOAD follows last RUN pulse directly.
        clear_mon();
        step_div = 16'd3;
        push(32'd10, 32'd20, 32'd30, 32'd2);
        push(32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
        pulse_start();
        wait_done("b2b");
        check("b2b_nwr", 64'(wq.size()), 64'(NCLR + 14));
        check("b2b_nstep", 64'(st.size()), 64'd3);
        if (wq.size() == NCLR + 14 && st.size() == 3) begin
            check("b2b_gap", 64'(wt[NCLR + 6] - st[1]), 64'd1);
            check("b2b_a_lo", 64'(wq[NCLR + 8]), 64'({8'd4, 32'hFFFF_FFFF, 1'b0, 1'b1}));
            check("b2b_a_hi", 64'(wq[NCLR + 9]), 64'({8'd4, 32'hFFFF_FFFF, 1'b1, 1'b0}));
            check("b2b_j_lo", 64'(wq[NCLR + 10]), 64'({8'd5, 32'hFFFF_FFFE, 1'b0, 1'b1}));
        end
        check("b2b_segcnt", 64'(seg_count), 64'd2);

        // FIFO full: fifth push dropped, exactly four segments execute.
        clear_mon();
        step_div = 16'd0;
        for (int i = 0; i < DEPTH; i++) push(32'(i + 1), 32'd0, 32'd0, 32'd1);
        check("full_ready", 64'(seg_ready), 64'd0);
        push(32'd99, 32'd0, 32'd0, 32'd1);
        check("full_ready2", 64'(seg_ready), 64'd0);
        pulse_start();
        wait_done("full");
        nld = 0;
        foreach (wq[k]) if (wq[k].hi != wq[k].lo) nld++;
        check("full_nload", 64'(nld), 64'd24);
        check("full_nstep", 64'(st.size()), 64'd4);
        check("full_segcnt", 64'(seg_count), 64'd4);
        check("full_ready_after", 64'(seg_ready), 64'd1);

        // Abort during RUN after one of ten steps, with a second segment still queued.
        clear_mon();
        step_div = 16'd5;
        push(32'd1, 32'd2, 32'd3, 32'd10);
        push(32'd4, 32'd5, 32'd6, 32'd1);
        pulse_start();
        begin
            int n = 0;
            while (st.size() == 0 && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            check("abort_step_timeout", 64'(n >= 500), 64'd0);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("abort");
        check("abort_nstep", 64'(st.size()), 64'd1);
        check("abort_segcnt", 64'(seg_count), 64'd0);
        check("abort_ready", 64'(seg_ready), 64'd1);
        if (wq.size() >= 2) begin
            check("abort_halt4", 64'(wq[wq.size()-2]), 64'({8'd4, 32'd0, 1'b1, 1'b1}));
            check("abort_halt5", 64'(wq[wq.size()-1]), 64'({8'd5, 32'd0, 1'b1, 1'b1}));
        end else begin
            check("abort_nwr", 64'(wq.size()), 64'd2);
        end

        // Start on the flushed (empty) FIFO goes straight to HALT.
        clear_mon();
        pulse_start();
        wait_done("empty");
        check("empty_nwr", 64'(wq.size()), 64'd2);
        if (wq.size() > 0)
            check("empty_first", 64'(wq[0]), 64'({8'd4, 32'd0, 1'b1, 1'b1}));
        check("empty_nstep", 64'(st.size()), 64'd0);
        check("empty_segcnt", 64'(seg_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
